sim_run_controller: RTL and testbench
=====================================

Name: sim_run_controller

Overview:
- Parametrised run-control and watchdog block for the top-level bench; generalises the inline halt/timeout/error logic into a reusable module.
- Sequences DUT reset, monitors N halt/commit channels and two error sources, enforces a programmable timeout and a no-commit deadlock window, drains after errors, and reports a sticky termination cause.
- Sits beside the monitor and banked memory; the bench calls $finish when done is high.

Parameters:
- CHANNELS, 8, number of halt/commit lanes monitored
- CNT_W, 32, width of the cycle, commit and timeout counters
- RESET_CYCLES, 2, cycles dut_rst is held after rst deasserts (must be ≥1)
- DRAIN_CYCLES, 5, cycles waited after an error before done
- DEADLOCK_CYCLES, 100000, consecutive cycles with no commit that count as a deadlock; 0 disables the check

Ports:
- clk  input  1  bench clock
- rst  input  1  synchronous active-high reset
- timeout_limit  input  CNT_W  run-cycle budget; 0 disables timeout
- halt  input  CHANNELS  per-lane halt from the monitor
- commit_valid  input  CHANNELS  per-lane retire strobe
- mon_error  input  1  monitor error flag
- mem_error  input  1  memory model error flag
- dut_rst  output  1  reset driven to the DUT
- done  output  1  run finished; stays high until rst
- status  output  3  0 RUNNING, 1 HALT, 2 TIMEOUT, 3 DEADLOCK, 4 ERROR
- cycle_count  output  CNT_W  RUN cycles elapsed, saturating
- commit_count  output  CNT_W  total commits, saturating

Behaviour:
- Clocking and reset: one clock; synchronous active-high reset. While rst=1: state RESET_HOLD, dut_rst=1, done=0, status=0, all counters 0.
- States: RESET_HOLD -> RUN -> (DRAIN) -> DONE.
- RESET_HOLD:
  - dut_rst stays 1 for exactly RESET_CYCLES cycles after the first cycle with rst=0.
  - Then state goes to RUN and dut_rst=0 in that same edge.
  - Inputs are ignored in this state.
- RUN:
  - Every cycle, cycle_count is incremented and saturates at all-ones.
  - commit_count adds popcount(commit_valid) and saturates.
  - An idle counter increments on cycles with commit_valid==0 and clears on any commit.
- Exit checks: evaluated on registered state each RUN cycle, highest priority first:
  1. mon_error|mem_error -> DRAIN; status=4 latched.
  2. |halt -> DONE; status=1.
  3. timeout_limit!=0 and cycle_count+1==timeout_limit -> DONE; status=2. Done is asserted on the edge that completes cycle timeout_limit.
  4. DEADLOCK_CYCLES!=0 and idle counter reaches DEADLOCK_CYCLES -> DONE; status=3.
- Counters on the exit cycle: commits presented on the exit cycle are still counted, and cycle_count includes the exit cycle.
- DRAIN:
  - Waits DRAIN_CYCLES cycles; counters keep running.
  - Halt, timeout and further errors are ignored, so status stays 4.
  - Then state goes to DONE. DRAIN_CYCLES=0 means go to DONE on the next edge.
- DONE:
  - done=1 and status is frozen.
  - Counters are frozen, and all inputs are ignored until rst.
- Status latching: status is written exactly once per run (first cause wins) and reads 0 until that write.
- Simultaneous events: resolved by the priority order above, e.g. error+halt in the same cycle gives ERROR.
- Reset mid-run or mid-drain: returns to RESET_HOLD immediately, re-asserts dut_rst, clears done, status and counters.
- Widths:
  - Popcount uses $clog2(CHANNELS+1) bits and is zero-extended to CNT_W.
  - Saturation is checked on the full sum.
  - Idle counter width is $clog2(DEADLOCK_CYCLES+1), minimum 1.

Test Plan:
- rst high 3 cycles then low, RESET_CYCLES=2 -> dut_rst high through 2 cycles after rst falls; RUN entered; cycle_count=0 on the first RUN cycle.
- Halt: commit_valid=8'h03 for 10 cycles, then halt[5]=1 -> next edge done=1, status=1, commit_count=20, cycle_count=11; further inputs leave all outputs unchanged.
- Timeout: timeout_limit=50, steady commits, no halt -> done on the edge ending cycle 50, status=2, cycle_count=50. With timeout_limit=0 and a 1000-cycle run, no timeout fires.
- Error drain: mem_error pulse at RUN cycle 7, halt at cycle 8, DRAIN_CYCLES=5 -> done rises 6 edges after the error, status=4 (not 1).
- Deadlock: DEADLOCK_CYCLES=16, commits stop at cycle 4 -> status=3 after 16 idle cycles. A single commit at idle count 15 resets the window.
- Reset and saturation:
  - Reset mid-drain -> dut_rst=1, done=0, status=0 on the next edge.
  - With CNT_W=4 and all lanes committing, commit_count saturates at 15.

Source files
------------

// File: rtl/sim_run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sim_run_controller
//  Purpose  : Run-control and watchdog for the top-level bench. Sequences the
//             DUT reset, watches per-lane halt/commit strobes and two error
//             flags, enforces a run-cycle budget and a no-commit deadlock
//             window, drains after an error and reports a sticky cause.
//  Ports    : clk, rst            - bench clock, synchronous active-high reset
//             timeout_limit       - run-cycle budget (0 = no timeout)
//             halt, commit_valid  - per-lane halt and retire strobes
//             mon_error, mem_error- error flags from monitor / memory model
//             dut_rst             - reset driven to the DUT
//             done                - run finished, held until rst
//             status              - 0 RUN,1 HALT,2 TIMEOUT,3 DEADLOCK,4 ERROR
//             cycle_count         - RUN/DRAIN cycles elapsed, saturating
//             commit_count        - total commits, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module sim_run_controller #(
   parameter int CHANNELS        = 8,
   parameter int CNT_W           = 32,
   parameter int RESET_CYCLES    = 2,
   parameter int DRAIN_CYCLES    = 5,
   parameter int DEADLOCK_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] timeout_limit,
   input  logic [CHANNELS-1:0] halt,
   input  logic [CHANNELS-1:0] commit_valid,
   input  logic             mon_error,
   input  logic             mem_error,
   output logic             dut_rst,
   output logic             done,
   output logic [2:0]       status,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] commit_count
);

   localparam int PC_W    = $clog2(CHANNELS + 1);
   localparam int RST_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int IDLE_W  = (DEADLOCK_CYCLES > 0) ? $clog2(DEADLOCK_CYCLES + 1) : 1;

   localparam logic [RST_W-1:0]   c_RST_LAST   = RST_W'(RESET_CYCLES - 1);
   localparam logic [DRAIN_W-1:0] c_DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [IDLE_W-1:0]  c_IDLE_LAST  = IDLE_W'((DEADLOCK_CYCLES > 0) ? DEADLOCK_CYCLES - 1 : 0);

   localparam logic [2:0] c_ST_RUNNING  = 3'd0;
   localparam logic [2:0] c_ST_HALT     = 3'd1;
   localparam logic [2:0] c_ST_TIMEOUT  = 3'd2;
   localparam logic [2:0] c_ST_DEADLOCK = 3'd3;
   localparam logic [2:0] c_ST_ERROR    = 3'd4;

   typedef enum logic [1:0] {
      S_RESET_HOLD = 2'd0,
      S_RUN        = 2'd1,
      S_DRAIN      = 2'd2,
      S_DONE       = 2'd3
   } state_t;

   state_t             r_state;
   logic [RST_W-1:0]   r_rst_cnt;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [IDLE_W-1:0]  r_idle_cnt;

   logic [PC_W-1:0]    w_popcount;
   logic [CNT_W:0]     w_commit_sum;
   logic [CNT_W-1:0]   w_commit_next;
   logic [CNT_W-1:0]   w_cycle_next;
   logic [CNT_W:0]     w_cycle_plus1;
   logic               w_any_commit;
   logic               w_timeout_hit;
   logic               w_deadlock_hit;

   always_comb begin
      w_popcount = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_popcount = w_popcount + PC_W'(commit_valid[i]);
      end
   end

   // Sum carried one bit wider so saturation is judged on the true total.
   assign w_commit_sum  = {1'b0, commit_count} + (CNT_W+1)'(w_popcount);
   assign w_commit_next = w_commit_sum[CNT_W] ? {CNT_W{1'b1}} : w_commit_sum[CNT_W-1:0];
   assign w_cycle_next  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

   // Fires on the cycle that completes cycle number timeout_limit.
   assign w_cycle_plus1  = {1'b0, cycle_count} + (CNT_W+1)'(1);
   assign w_timeout_hit  = (timeout_limit != '0) && (w_cycle_plus1 == {1'b0, timeout_limit});

   assign w_any_commit   = |commit_valid;
   // This idle cycle is the DEADLOCK_CYCLES-th consecutive one.
   assign w_deadlock_hit = (DEADLOCK_CYCLES != 0) && !w_any_commit && (r_idle_cnt == c_IDLE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_RESET_HOLD;
         r_rst_cnt    <= '0;
         r_drain_cnt  <= '0;
         r_idle_cnt   <= '0;
         dut_rst      <= 1'b1;
         done         <= 1'b0;
         status       <= c_ST_RUNNING;
         cycle_count  <= '0;
         commit_count <= '0;
      end else begin
         case (r_state)
            S_RESET_HOLD: begin
               if (r_rst_cnt == c_RST_LAST) begin
                  r_state <= S_RUN;
                  dut_rst <= 1'b0;
               end else begin
                  r_rst_cnt <= r_rst_cnt + RST_W'(1);
               end
            end

            S_RUN: begin
               cycle_count  <= w_cycle_next;
               commit_count <= w_commit_next;
               r_idle_cnt   <= w_any_commit ? '0 : r_idle_cnt + IDLE_W'(1);
               if (mon_error || mem_error) begin
                  status      <= c_ST_ERROR;
                  r_drain_cnt <= '0;
                  if (DRAIN_CYCLES == 0) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else if (|halt) begin
                  status  <= c_ST_HALT;
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end else if (w_timeout_hit) begin
                  status  <= c_ST_TIMEOUT;
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end else if (w_deadlock_hit) begin
                  status  <= c_ST_DEADLOCK;
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end
            end

            S_DRAIN: begin
               cycle_count  <= w_cycle_next;
               commit_count <= w_commit_next;
               if (r_drain_cnt == c_DRAIN_LAST) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
               end
            end

            S_DONE: begin
               // Everything frozen until rst.
            end

            default: r_state <= S_RESET_HOLD;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sim_run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sim_run_controller
//  Purpose  : Directed self-checking bench for sim_run_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sim_run_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] timeout_limit;
   logic [7:0]  halt;
   logic [7:0]  commit_valid;
   logic        mon_error;
   logic        mem_error;
   logic        dut_rst;
   logic        done;
   logic [2:0]  status;
   logic [31:0] cycle_count;
   logic [31:0] commit_count;

   // Narrow-counter instance used for saturation.
   logic        s_rst;
   logic [3:0]  s_timeout_limit;
   logic [7:0]  s_halt;
   logic [7:0]  s_commit_valid;
   logic        s_dut_rst;
   logic        s_done;
   logic [2:0]  s_status;
   logic [3:0]  s_cycle_count;
   logic [3:0]  s_commit_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sim_run_controller #(
      .CHANNELS(8), .CNT_W(32), .RESET_CYCLES(2),
      .DRAIN_CYCLES(5), .DEADLOCK_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .timeout_limit(timeout_limit), .halt(halt),
      .commit_valid(commit_valid), .mon_error(mon_error), .mem_error(mem_error),
      .dut_rst(dut_rst), .done(done), .status(status),
      .cycle_count(cycle_count), .commit_count(commit_count)
   );

   sim_run_controller #(
      .CHANNELS(8), .CNT_W(4), .RESET_CYCLES(2),
      .DRAIN_CYCLES(5), .DEADLOCK_CYCLES(0)
   ) u_sat (
      .clk(clk), .rst(s_rst), .timeout_limit(s_timeout_limit), .halt(s_halt),
      .commit_valid(s_commit_valid), .mon_error(1'b0), .mem_error(1'b0),
      .dut_rst(s_dut_rst), .done(s_done), .status(s_status),
      .cycle_count(s_cycle_count), .commit_count(s_commit_count)
   );

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset with rst high 3 cycles, then release and wait out RESET_HOLD.
   task automatic enter_run();
      rst = 1'b1; halt = '0; commit_valid = '0; mon_error = 1'b0; mem_error = 1'b0;
      step(3);
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_reset();
      rst = 1'b1; halt = '0; commit_valid = '0; mon_error = 1'b0; mem_error = 1'b0;
      timeout_limit = '0;
      step(3);
      checks++;
      if (dut_rst !== 1'b1 || done !== 1'b0 || status !== 3'd0 || cycle_count !== 32'd0 || commit_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: dut_rst=%b done=%b status=%0d cyc=%0d com=%0d, required 1 0 0 0 0",
                  dut_rst, done, status, cycle_count, commit_count);
      end
      rst = 1'b0;
      step(1);
      checks++;
      if (dut_rst !== 1'b1) begin
         errors++;
         $display("FAIL reset_hold_1: dut_rst=%b, required 1", dut_rst);
      end
      step(1);
      checks++;
      if (dut_rst !== 1'b0 || cycle_count !== 32'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: dut_rst=%b cyc=%0d done=%b, required 0 0 0", dut_rst, cycle_count, done);
      end
   endtask

   task automatic test_halt();
      enter_run();
      commit_valid = 8'h03;
      step(10);
      commit_valid = 8'h00;
      halt = 8'h20;
      step(1);
      checks++;
      if (done !== 1'b1 || status !== 3'd1 || commit_count !== 32'd20 || cycle_count !== 32'd11) begin
         errors++;
         $display("FAIL halt_exit: done=%b status=%0d com=%0d cyc=%0d, required 1 1 20 11",
                  done, status, commit_count, cycle_count);
      end
      halt = '0; commit_valid = 8'hFF; mon_error = 1'b1; timeout_limit = 32'd2;
      step(3);
      checks++;
      if (done !== 1'b1 || status !== 3'd1 || commit_count !== 32'd20 || cycle_count !== 32'd11 || dut_rst !== 1'b0) begin
         errors++;
         $display("FAIL done_frozen: done=%b status=%0d com=%0d cyc=%0d dut_rst=%b, required 1 1 20 11 0",
                  done, status, commit_count, cycle_count, dut_rst);
      end
      mon_error = 1'b0; commit_valid = '0; timeout_limit = '0;
   endtask

   task automatic test_timeout();
      timeout_limit = 32'd50;
      enter_run();
      commit_valid = 8'h01;
      step(49);
      checks++;
      if (done !== 1'b0 || cycle_count !== 32'd49) begin
         errors++;
         $display("FAIL timeout_early: done=%b cyc=%0d, required 0 49", done, cycle_count);
      end
      step(1);
      checks++;
      if (done !== 1'b1 || status !== 3'd2 || cycle_count !== 32'd50 || commit_count !== 32'd50) begin
         errors++;
         $display("FAIL timeout_exit: done=%b status=%0d cyc=%0d com=%0d, required 1 2 50 50",
                  done, status, cycle_count, commit_count);
      end
      timeout_limit = '0;
      enter_run();
      commit_valid = 8'h01;
      step(1000);
      checks++;
      if (done !== 1'b0 || status !== 3'd0 || cycle_count !== 32'd1000) begin
         errors++;
         $display("FAIL timeout_disabled: done=%b status=%0d cyc=%0d, required 0 0 1000", done, status, cycle_count);
      end
      commit_valid = '0;
   endtask

   task automatic test_error_drain();
      enter_run();
      commit_valid = 8'h01;
      step(6);
      mem_error = 1'b1;          // RUN cycle 7
      step(1);
      mem_error = 1'b0;
      checks++;
      if (status !== 3'd4 || done !== 1'b0) begin
         errors++;
         $display("FAIL error_latch: status=%0d done=%b, required 4 0", status, done);
      end
      halt = 8'h01;              // cycle 8, must be ignored
      step(1);
      halt = '0;
      step(3);
      checks++;
      if (done !== 1'b0 || status !== 3'd4) begin
         errors++;
         $display("FAIL drain_early: done=%b status=%0d after 5 edges, required 0 4", done, status);
      end
      step(1);
      checks++;
      if (done !== 1'b1 || status !== 3'd4 || cycle_count !== 32'd12 || commit_count !== 32'd12) begin
         errors++;
         $display("FAIL drain_done: done=%b status=%0d cyc=%0d com=%0d, required 1 4 12 12",
                  done, status, cycle_count, commit_count);
      end
      commit_valid = '0;
   endtask

   task automatic test_priority();
      // Halt and timeout together: halt outranks timeout.
      timeout_limit = 32'd3;
      enter_run();
      commit_valid = 8'h01;
      step(2);
      halt = 8'h80;
      step(1);
      halt = '0;
      checks++;
      if (done !== 1'b1 || status !== 3'd1) begin
         errors++;
         $display("FAIL prio_halt_timeout: done=%b status=%0d, required 1 1", done, status);
      end
      timeout_limit = '0;
      // Error and halt together: error wins and drains.
      enter_run();
      halt = 8'h01; mon_error = 1'b1;
      step(1);
      halt = '0; mon_error = 1'b0;
      checks++;
      if (done !== 1'b0 || status !== 3'd4) begin
         errors++;
         $display("FAIL prio_error_halt: done=%b status=%0d, required 0 4", done, status);
      end
      commit_valid = '0;
   endtask

   task automatic test_deadlock();
      enter_run();
      commit_valid = 8'h01;
      step(3);
      commit_valid = 8'h00;      // commits stop at cycle 4
      step(15);
      checks++;
      if (done !== 1'b0 || status !== 3'd0) begin
         errors++;
         $display("FAIL deadlock_early: done=%b status=%0d, required 0 0", done, status);
      end
      step(1);
      checks++;
      if (done !== 1'b1 || status !== 3'd3 || cycle_count !== 32'd19) begin
         errors++;
         $display("FAIL deadlock_exit: done=%b status=%0d cyc=%0d, required 1 3 19", done, status, cycle_count);
      end
      enter_run();
      step(15);
      commit_valid = 8'h10;      // single commit at idle count 15
      step(1);
      commit_valid = 8'h00;
      step(15);
      checks++;
      if (done !== 1'b0 || status !== 3'd0) begin
         errors++;
         $display("FAIL deadlock_window_reset: done=%b status=%0d, required 0 0", done, status);
      end
      step(1);
      checks++;
      if (done !== 1'b1 || status !== 3'd3 || cycle_count !== 32'd32 || commit_count !== 32'd1) begin
         errors++;
         $display("FAIL deadlock_after_window: done=%b status=%0d cyc=%0d com=%0d, required 1 3 32 1",
                  done, status, cycle_count, commit_count);
      end
   endtask

   task automatic test_reset_mid_drain();
      enter_run();
      commit_valid = 8'h01;
      step(4);
      mon_error = 1'b1;
      step(1);
      mon_error = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
      checks++;
      if (dut_rst !== 1'b1 || done !== 1'b0 || status !== 3'd0 || cycle_count !== 32'd0 || commit_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_drain: dut_rst=%b done=%b status=%0d cyc=%0d com=%0d, required 1 0 0 0 0",
                  dut_rst, done, status, cycle_count, commit_count);
      end
      rst = 1'b0;
      commit_valid = '0;
      step(2);
   endtask

   task automatic test_saturation();
      s_rst = 1'b1; s_halt = '0; s_commit_valid = '0; s_timeout_limit = '0;
      step(3);
      s_rst = 1'b0;
      step(2);
      s_commit_valid = 8'hFF;
      step(1);
      checks++;
      if (s_commit_count !== 4'd8) begin
         errors++;
         $display("FAIL sat_first: commit_count=%0d, required 8", s_commit_count);
      end
      step(1);
      checks++;
      if (s_commit_count !== 4'd15) begin
         errors++;
         $display("FAIL sat_commit: commit_count=%0d, required 15", s_commit_count);
      end
      step(18);
      checks++;
      if (s_commit_count !== 4'd15 || s_cycle_count !== 4'd15 || s_done !== 1'b0) begin
         errors++;
         $display("FAIL sat_hold: commit_count=%0d cycle_count=%0d done=%b, required 15 15 0",
                  s_commit_count, s_cycle_count, s_done);
      end
      s_commit_valid = '0;
   endtask

   initial begin
      rst = 1'b1; timeout_limit = '0; halt = '0; commit_valid = '0;
      mon_error = 1'b0; mem_error = 1'b0;
      s_rst = 1'b1; s_timeout_limit = '0; s_halt = '0; s_commit_valid = '0;
      #2;
      test_reset();
      test_halt();
      test_timeout();
      test_error_drain();
      test_priority();
      test_deadlock();
      test_reset_mid_drain();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
